// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between the fabric SPI master and the register slave.
interface spi_slave_regs_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode 0 slave: oversamples the SPI pins with sysclk, decodes 16-bit
// {cmd, addr, payload} frames into register writes/reads, and exposes
// register 0 as the LED brightness value.
module spi_slave_regs #(
    parameter int                  CMD_BITS         = 4,
    parameter int                  ADDR_BITS        = 4,
    parameter int                  PAYLOAD_BITS     = 8,
    parameter int                  NUM_REGS         = 4,
    parameter int                  BRIGHTNESS_WIDTH = 7,
    parameter logic [CMD_BITS-1:0] CMD_WRITE        = 4'hA,
    parameter logic [CMD_BITS-1:0] CMD_READ         = 4'h5
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    spi_slave_regs_if.slave             spi,
    output logic [BRIGHTNESS_WIDTH-1:0] o_brightness,
    output logic                        o_wr_strobe,
    output logic [ADDR_BITS-1:0]        o_wr_addr,
    output logic [PAYLOAD_BITS-1:0]     o_wr_data,
    output logic                        o_frame_err
);

    localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_BITS:0] NUM_REGS_L = NUM_REGS[ADDR_BITS:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchronizer stages: _p1 is the synced level, sclk_p2 the previous one.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1;
    logic mosi_p0, mosi_p1;

    logic sclk_rise;
    logic sclk_fall;
    logic in_frame;

    logic [4:0]              bit_cnt;
    logic [CMD_BITS-1:0]     opcode;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [PAYLOAD_BITS-1:0] rx_shift;
    logic [PAYLOAD_BITS-1:0] rx_next;
    logic [PAYLOAD_BITS-1:0] tx_shift;
    logic [CMD_BITS-1:0]     op_next;
    logic [ADDR_BITS-1:0]    addr_next;
    logic                    miso_q;

    logic [PAYLOAD_BITS-1:0] regs [NUM_REGS];

    logic go_cmd;
    logic op_done;
    logic addr_done;
    logic data_done;
    logic abort;

    logic addr_ok;
    logic addr_next_ok;
    logic rd_hit;

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign in_frame  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);

    // Value the shift register holds once the bit on the current rising edge lands.
    assign rx_next   = {rx_shift[PAYLOAD_BITS-2:0], mosi_p1};
    assign op_next   = rx_next[CMD_BITS-1:0];
    assign addr_next = rx_next[ADDR_BITS-1:0];

    assign addr_ok      = ({1'b0, addr_q} < NUM_REGS_L);
    assign addr_next_ok = ({1'b0, addr_next} < NUM_REGS_L);
    assign rd_hit       = (opcode == CMD_READ) && addr_next_ok;

    assign spi.miso     = miso_q;
    assign o_brightness = regs[0][BRIGHTNESS_WIDTH-1:0];

    // Bring the asynchronous SPI pins into the sysclk domain.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= spi.sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi.cs;
            cs_p1   <= cs_p0;
            mosi_p0 <= spi.mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // Frame state register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a high cs always wins over a same-cycle last edge.
    always_comb begin
        state_nxt = state;
        go_cmd    = 1'b0;
        op_done   = 1'b0;
        addr_done = 1'b0;
        data_done = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cs_p1) begin
                    state_nxt = S_CMD;
                    go_cmd    = 1'b1;
                end
            end
            S_CMD: begin
                if (cs_p1) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end else if (sclk_rise && (bit_cnt == 5'(CMD_BITS - 1))) begin
                    state_nxt = S_ADDR;
                    op_done   = 1'b1;
                end
            end
            S_ADDR: begin
                if (cs_p1) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end else if (sclk_rise && (bit_cnt == 5'(ADDR_BITS - 1))) begin
                    state_nxt = S_DATA;
                    addr_done = 1'b1;
                end
            end
            S_DATA: begin
                if (cs_p1) begin
                    state_nxt = S_IDLE;
                    abort     = 1'b1;
                end else if (sclk_rise && (bit_cnt == 5'(PAYLOAD_BITS - 1))) begin
                    state_nxt = S_DONE;
                    data_done = 1'b1;
                end
            end
            S_DONE: begin
                if (cs_p1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit counter restarts on every state entry and counts rising edges within a field.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (state_nxt != state) begin
            bit_cnt <= '0;
        end else if (sclk_rise && in_frame) begin
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Latch the decoded opcode and address at the end of their fields.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            opcode <= '0;
            addr_q <= '0;
        end else begin
            if (op_done) begin
                opcode <= op_next;
            end
            if (addr_done) begin
                addr_q <= addr_next;
            end
        end
    end

    // Receive shifter: cleared at frame start, shifts mosi on each rising edge.
    always_ff @(posedge sysclk) begin
        if (go_cmd) begin
            rx_shift <= '0;
        end else if (sclk_rise && in_frame) begin
            rx_shift <= rx_next;
        end
    end

    // Transmit shifter: loaded when the address completes, advanced on falling edges.
    always_ff @(posedge sysclk) begin
        if (addr_done) begin
            tx_shift <= rd_hit ? regs[addr_next[IDX_W-1:0]] : '0;
        end else if (sclk_fall && (state == S_DATA)) begin
            tx_shift <= {tx_shift[PAYLOAD_BITS-2:0], 1'b0};
        end
    end

    // miso carries the tx MSB only during the payload field, otherwise 0.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
        end else if (state != S_DATA) begin
            miso_q <= 1'b0;
        end else if (sclk_fall) begin
            miso_q <= tx_shift[PAYLOAD_BITS-1];
        end
    end

    // Register file write commit with the strobe and held write report.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
        end else begin
            o_wr_strobe <= 1'b0;
            if (data_done && (opcode == CMD_WRITE) && addr_ok) begin
                regs[addr_q[IDX_W-1:0]] <= rx_next;
                o_wr_strobe             <= 1'b1;
                o_wr_addr               <= addr_q;
                o_wr_data               <= rx_next;
            end
        end
    end

    // One-cycle error pulse when a frame is cut short by cs.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= abort;
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: a small SPI master drives frames,
// a register model predicts writes and read-back words, and a monitor
// compares every write strobe against the queue of predicted commits.
module tb_spi_slave_regs;

    localparam int HALF = 5;

    logic sysclk;
    logic rst_n;

    logic [6:0] o_brightness;
    logic       o_wr_strobe;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_frame_err;

    spi_slave_regs_if spi ();

    spi_slave_regs dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .spi          (spi),
        .o_brightness (o_brightness),
        .o_wr_strobe  (o_wr_strobe),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_frame_err  (o_frame_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;

    logic [11:0] wr_q [$];
    logic [15:0] rd_q [$];
    logic [7:0]  model [4];

    initial sysclk = 1'b0;
    always #4 sysclk = ~sysclk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Write-strobe and frame-error monitor, sampled on the falling sysclk edge.
    always @(negedge sysclk) begin
        if (rst_n) begin
            if (o_frame_err) err_cnt++;
            if (o_wr_strobe) begin
                logic [11:0] e;
                strobe_cnt++;
                chk_eq("strobe_expected", 32'(o_wr_strobe), 32'(wr_q.size() != 0));
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    chk_eq("wr_addr", 32'(o_wr_addr), 32'(e[11:8]));
                    chk_eq("wr_data", 32'(o_wr_data), 32'(e[7:0]));
                    if (e[11:8] == 4'd0)
                        chk_eq("bright_at_strobe", 32'(o_brightness), 32'(e[6:0]));
                end
            end
        end
    end

    task automatic spi_xfer(input logic [15:0] word, input int nbits, input int extra,
                            input bit end_cs, input int gap, output logic [15:0] rx);
        rx = '0;
        spi.cs = 1'b0;
        cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = word[15-i];
            cyc(HALF);
            spi.sclk = 1'b1;
            rx = {rx[14:0], spi.miso};
            cyc(HALF);
            spi.sclk = 1'b0;
        end
        for (int i = 0; i < extra; i++) begin
            spi.mosi = 1'b1;
            cyc(HALF);
            spi.sclk = 1'b1;
            cyc(HALF);
            spi.sclk = 1'b0;
        end
        if (end_cs) begin
            cyc(HALF);
            spi.cs = 1'b1;
            cyc(gap);
        end
    endtask

    task automatic run_frame(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] data,
                             input int nbits, input int extra, input int gap);
        logic [15:0] rx;
        logic [15:0] exp_rx;
        int s0, e0;
        bit full, commit, is_rd;
        full   = (nbits == 16);
        commit = full && (op == 4'hA) && (addr < 4'd4);
        is_rd  = full && (op == 4'h5);
        exp_rx = {8'h00, (addr < 4'd4) ? model[addr[1:0]] : 8'h00};
        if (commit) begin
            wr_q.push_back({addr, data});
            model[addr[1:0]] = data;
        end
        if (is_rd) rd_q.push_back(exp_rx);
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_xfer({op, addr, data}, nbits, extra, 1'b1, gap, rx);
        if (is_rd) chk_eq("rd_word", 32'(rx), 32'(rd_q.pop_front()));
        chk_eq("strobe_count", 32'(strobe_cnt - s0), 32'(commit));
        chk_eq("frame_err_count", 32'(err_cnt - e0), 32'(!full));
        chk_eq("brightness", 32'(o_brightness), 32'(model[0][6:0]));
        chk_eq("miso_idle", 32'(spi.miso), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_miso"},   32'(spi.miso), 32'd0);
        chk_eq({tag, "_bright"}, 32'(o_brightness), 32'd0);
        chk_eq({tag, "_strobe"}, 32'(o_wr_strobe), 32'd0);
        chk_eq({tag, "_waddr"},  32'(o_wr_addr), 32'd0);
        chk_eq({tag, "_wdata"},  32'(o_wr_data), 32'd0);
        chk_eq({tag, "_ferr"},   32'(o_frame_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        int s0, e0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        rst_n    = 1'b0;
        spi.sclk = 1'b0;
        spi.cs   = 1'b1;
        spi.mosi = 1'b0;
        cyc(5);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc(5);

        // Write to reg 0.
        run_frame(4'hA, 4'h0, 8'h55, 16, 0, 8);
        chk_eq("wr_addr_held", 32'(o_wr_addr), 32'h0);
        chk_eq("wr_data_held", 32'(o_wr_data), 32'h55);

        // Write then read back.
        run_frame(4'hA, 4'h2, 8'hC3, 16, 0, 8);
        run_frame(4'h5, 4'h2, 8'h00, 16, 0, 8);
        run_frame(4'h5, 4'h0, 8'h00, 16, 0, 8);

        // Out-of-range address, unknown opcode.
        run_frame(4'hA, 4'h7, 8'hFF, 16, 0, 8);
        run_frame(4'h5, 4'h7, 8'hAA, 16, 0, 8);
        run_frame(4'h3, 4'h1, 8'h99, 16, 0, 8);
        chk_eq("wr_addr_kept", 32'(o_wr_addr), 32'h2);
        chk_eq("wr_data_kept", 32'(o_wr_data), 32'hC3);

        // Abort after 10 bits, then the same frame in full.
        run_frame(4'hA, 4'h0, 8'h12, 10, 0, 8);
        run_frame(4'h5, 4'h0, 8'h00, 16, 0, 8);
        run_frame(4'hA, 4'h0, 8'h12, 16, 0, 8);

        // Extra clocks after the payload, then back-to-back frames.
        run_frame(4'hA, 4'h1, 8'h3C, 16, 2, 3);
        run_frame(4'hA, 4'h2, 8'h11, 16, 0, 3);
        run_frame(4'hA, 4'h3, 8'h22, 16, 0, 8);
        run_frame(4'h5, 4'h3, 8'h00, 16, 0, 8);
        run_frame(4'h5, 4'h1, 8'h00, 16, 0, 8);

        // Asynchronous reset in the middle of the payload.
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_xfer(16'hA07F, 12, 0, 1'b0, 0, rx);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        spi.cs = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(6);
        chk_eq("reset_strobe_count", 32'(strobe_cnt - s0), 32'd0);
        chk_eq("reset_ferr_count", 32'(err_cnt - e0), 32'd0);
        run_frame(4'hA, 4'h1, 8'h01, 16, 0, 8);
        run_frame(4'h5, 4'h1, 8'h00, 16, 0, 8);
        run_frame(4'h5, 4'h2, 8'h00, 16, 0, 8);

        cyc(10);
        chk_eq("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
